// File: rtl/battleship_pkg.sv
// ---------------------------------------------------------------------------
// battleship_pkg
//  Shared definitions for the battleship game blocks.
//  - game_state_t : game phase encoding as seen by the renderer and the
//                   seven-segment decoder.
//  - idx_w/hit_w/tmr_w : width helpers for cell index, hit counter and turn
//                   timer, each at least 1 bit wide.
//  - popcount     : ones count over a zero-extended ship bitmap. The
//                   placement controller uses it too.
// ---------------------------------------------------------------------------
package battleship_pkg;

  typedef enum logic [2:0] {
    P1_PLACE = 3'd0,
    P2_PLACE = 3'd1,
    P1_ATK   = 3'd2,
    P2_ATK   = 3'd3,
    P1_WIN   = 3'd4,
    P2_WIN   = 3'd5
  } game_state_t;

  // Bitmaps are zero-extended to this width before counting.
  localparam int POP_MAX = 256;
  localparam int POP_W   = 9;

  // Bits needed to hold the values 0..max_value, at least 1.
  function automatic int width_of(input int max_value);
    int w;
    w = $clog2(max_value + 1);
    return (w < 1) ? 1 : w;
  endfunction

  // Bits needed to address cells 0..cells-1.
  function automatic int idx_w(input int cells);
    return (cells <= 1) ? 1 : $clog2(cells);
  endfunction

  function automatic int hit_w(input int ship_cells);
    return width_of(ship_cells);
  endfunction

  function automatic int tmr_w(input int timeout);
    return width_of(timeout);
  endfunction

  function automatic logic [POP_W-1:0] popcount(input logic [POP_MAX-1:0] v);
    logic [POP_W-1:0] cnt;
    cnt = {POP_W{1'b0}};
    for (int i = 0; i < POP_MAX; i++) begin
      cnt = cnt + {{(POP_W-1){1'b0}}, v[i]};
    end
    return cnt;
  endfunction

endpackage

// File: rtl/turn_timer.sv
// ---------------------------------------------------------------------------
// turn_timer
//  Per-turn countdown. Load has priority over decrement. The counter
//  decrements on each tick while run_i is high.
//  expire_o flags the tick that arrives at count 1. The owner reacts to that
//  flag by switching the turn and loading the counter again, so the counter
//  never rests at 0.
//  With TIMEOUT = 0 the counter is held at 0 and never expires.
//  Ports:
//   refresh_clk  in   clock
//   reset        in   asynchronous, active-high
//   load_i       in   reload counter with TIMEOUT
//   run_i        in   counting enabled (an attack turn is in progress)
//   tick_i       in   one-cycle 1 Hz enable
//   count_o      out  ticks remaining (registered)
//   expire_o     out  current tick ends the turn (combinational)
// ---------------------------------------------------------------------------
module turn_timer
  import battleship_pkg::*;
#(
  parameter  int TIMEOUT = 10,
  localparam int TMR_W   = tmr_w(TIMEOUT)
) (
  input  logic             refresh_clk,
  input  logic             reset,
  input  logic             load_i,
  input  logic             run_i,
  input  logic             tick_i,
  output logic [TMR_W-1:0] count_o,
  output logic             expire_o
);

  localparam logic [TMR_W-1:0] LOAD_VAL = TMR_W'(TIMEOUT);
  localparam logic [TMR_W-1:0] ONE      = TMR_W'(1);
  localparam logic [TMR_W-1:0] ZERO     = TMR_W'(0);

  logic [TMR_W-1:0] count_q;
  logic [TMR_W-1:0] count_d;

  // Next count: load, then decrement, otherwise hold.
  always_comb begin
    count_d = count_q;
    if (TIMEOUT == 0) begin
      count_d = ZERO;
    end else if (load_i) begin
      count_d = LOAD_VAL;
    end else if (run_i && tick_i && (count_q != ZERO)) begin
      count_d = count_q - ONE;
    end else begin
      count_d = count_q;
    end
  end

  // Counter register.
  always_ff @(posedge refresh_clk or posedge reset) begin
    if (reset) begin
      count_q <= LOAD_VAL;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o  = count_q;
  assign expire_o = (TIMEOUT != 0) && run_i && tick_i && (count_q == ONE);

endmodule

// File: rtl/turn_arbiter_fsm.sv
// ---------------------------------------------------------------------------
// turn_arbiter_fsm
//  Game-phase and turn controller for a GRID_W x GRID_H battleship board.
//  The game runs in this order: P1 placement, P2 placement, alternating
//  attacks, and a win. This block owns both shot maps and both hit counters.
//  It ignores repeat shots and out-of-range shots. It also forfeits a turn
//  when the turn timer runs out.
//  Build option: define EXTRA_TURN_ON_HIT_EN to let a player who lands a hit
//  that does not win the game keep the turn. Misses and timeouts always pass
//  the turn.
//  Ports:
//   refresh_clk   in   clock
//   reset         in   asynchronous, active-high
//   tick_1hz      in   one-cycle 1 Hz enable
//   done_pulse    in   placement done request
//   attack_pulse  in   fire request
//   cursor_idx    in   target cell, row*GRID_W+col
//   p1_ships      in   P1 ship bitmap
//   p2_ships      in   P2 ship bitmap
//   game_state    out  current phase (game_state_t encoding)
//   p1_shot_map   out  cells P1 fired at on P2's board
//   p2_shot_map   out  cells P2 fired at on P1's board
//   p1_hits       out  hits landed by P1
//   p2_hits       out  hits landed by P2
//   turn_timer    out  ticks remaining in the current attack turn
//   shot_strobe   out  pulse on an accepted shot
//   shot_hit      out  hit flag, valid with shot_strobe
//   place_err     out  pulse on a rejected done request
// ---------------------------------------------------------------------------
module turn_arbiter_fsm
  import battleship_pkg::*;
#(
  parameter  int GRID_W       = 6,
  parameter  int GRID_H       = 6,
  parameter  int SHIP_CELLS   = 5,
  parameter  int TURN_TIMEOUT = 10,
  localparam int CELLS        = GRID_W * GRID_H,
  localparam int IDX_W        = idx_w(CELLS),
  localparam int HIT_W        = hit_w(SHIP_CELLS),
  localparam int TMR_W        = tmr_w(TURN_TIMEOUT)
) (
  input  logic             refresh_clk,
  input  logic             reset,
  input  logic             tick_1hz,
  input  logic             done_pulse,
  input  logic             attack_pulse,
  input  logic [IDX_W-1:0] cursor_idx,
  input  logic [CELLS-1:0] p1_ships,
  input  logic [CELLS-1:0] p2_ships,
  output logic [2:0]       game_state,
  output logic [CELLS-1:0] p1_shot_map,
  output logic [CELLS-1:0] p2_shot_map,
  output logic [HIT_W-1:0] p1_hits,
  output logic [HIT_W-1:0] p2_hits,
  output logic [TMR_W-1:0] turn_timer,
  output logic             shot_strobe,
  output logic             shot_hit,
  output logic             place_err
);

  localparam logic [POP_W-1:0] SHIP_CNT  = POP_W'(SHIP_CELLS);
  localparam logic [HIT_W-1:0] HIT_MAX   = HIT_W'(SHIP_CELLS);
  localparam logic [HIT_W-1:0] HIT_ZERO  = HIT_W'(0);
  localparam logic [31:0]      CELLS_U32 = 32'(CELLS);

  game_state_t state_q, state_d;
  logic [CELLS-1:0] p1_map_q, p1_map_d;
  logic [CELLS-1:0] p2_map_q, p2_map_d;
  logic [HIT_W-1:0] p1_hits_q, p1_hits_d;
  logic [HIT_W-1:0] p2_hits_q, p2_hits_d;
  logic             strobe_q, strobe_d;
  logic             hit_q, hit_d;
  logic             place_err_q, place_err_d;

  // Combinational helpers.
  logic               atk_s;
  logic               p2_turn_s;
  logic [CELLS-1:0]   place_ships_s;
  logic [POP_MAX-1:0] ships_ext_s;
  logic               place_ok_s;
  logic [CELLS-1:0]   atk_map_s;
  logic [CELLS-1:0]   new_map_s;
  logic [CELLS-1:0]   opp_ships_s;
  logic [HIT_W-1:0]   atk_hits_s;
  logic [HIT_W-1:0]   new_hits_s;
  logic               idx_ok_s;
  logic               shot_ok_s;
  logic               hit_s;
  logic               timer_load_s;
  logic               expire_s;
  logic               extra_turn_s;

  // The timer runs only during an attack turn. The FSM reloads it on every
  // turn change.
  turn_timer #(
    .TIMEOUT (TURN_TIMEOUT)
  ) u_turn_timer (
    .refresh_clk (refresh_clk),
    .reset       (reset),
    .load_i      (timer_load_s),
    .run_i       (atk_s),
    .tick_i      (tick_1hz),
    .count_o     (turn_timer),
    .expire_o    (expire_s)
  );

  // Pick the data of the current placer or attacker, and qualify the shot.
  always_comb begin
    atk_s     = (state_q == P1_ATK) || (state_q == P2_ATK);
    p2_turn_s = (state_q == P2_PLACE) || (state_q == P2_ATK);

    place_ships_s = p2_turn_s ? p2_ships : p1_ships;
    ships_ext_s   = {POP_MAX{1'b0}};
    ships_ext_s[CELLS-1:0] = place_ships_s;
    place_ok_s    = (popcount(ships_ext_s) == SHIP_CNT);

    atk_map_s   = p2_turn_s ? p2_map_q : p1_map_q;
    opp_ships_s = p2_turn_s ? p1_ships : p2_ships;
    atk_hits_s  = p2_turn_s ? p2_hits_q : p1_hits_q;

    // The range test is done at 32 bits so that a non-power-of-two board
    // rejects the unused high index codes.
    idx_ok_s  = ({{(32-IDX_W){1'b0}}, cursor_idx} < CELLS_U32);
    hit_s     = idx_ok_s && opp_ships_s[cursor_idx];
    shot_ok_s = attack_pulse && idx_ok_s && !atk_map_s[cursor_idx];

    new_map_s = atk_map_s;
    if (idx_ok_s) begin
      new_map_s[cursor_idx] = 1'b1;
    end else begin
      new_map_s = atk_map_s;
    end

    if (hit_s && (atk_hits_s != HIT_MAX)) begin
      new_hits_s = atk_hits_s + HIT_W'(1);
    end else begin
      new_hits_s = atk_hits_s;
    end

`ifdef EXTRA_TURN_ON_HIT_EN
    extra_turn_s = hit_s;
`else
    extra_turn_s = 1'b0;
`endif
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d      = state_q;
    p1_map_d     = p1_map_q;
    p2_map_d     = p2_map_q;
    p1_hits_d    = p1_hits_q;
    p2_hits_d    = p2_hits_q;
    strobe_d     = 1'b0;
    hit_d        = 1'b0;
    place_err_d  = 1'b0;
    timer_load_s = 1'b0;

    case (state_q)
      P1_PLACE, P2_PLACE: begin
        if (done_pulse) begin
          if (place_ok_s) begin
            if (state_q == P1_PLACE) begin
              state_d = P2_PLACE;
            end else begin
              state_d      = P1_ATK;
              timer_load_s = 1'b1;
            end
          end else begin
            place_err_d = 1'b1;
          end
        end else begin
          state_d = state_q;
        end
      end

      P1_ATK, P2_ATK: begin
        if (shot_ok_s) begin
          // An accepted shot has priority over a tick that ends the turn in
          // the same cycle.
          strobe_d = 1'b1;
          hit_d    = hit_s;
          if (p2_turn_s) begin
            p2_map_d  = new_map_s;
            p2_hits_d = new_hits_s;
          end else begin
            p1_map_d  = new_map_s;
            p1_hits_d = new_hits_s;
          end
          if (new_hits_s == HIT_MAX) begin
            state_d = p2_turn_s ? P2_WIN : P1_WIN;
          end else if (extra_turn_s) begin
            state_d      = state_q;
            timer_load_s = 1'b1;
          end else begin
            state_d      = p2_turn_s ? P1_ATK : P2_ATK;
            timer_load_s = 1'b1;
          end
        end else if (expire_s) begin
          state_d      = p2_turn_s ? P1_ATK : P2_ATK;
          timer_load_s = 1'b1;
        end else begin
          state_d = state_q;
        end
      end

      P1_WIN, P2_WIN: begin
        state_d = state_q;
      end

      default: begin
        state_d = P1_PLACE;
      end
    endcase
  end

  // State, shot maps, hit counters and strobes.
  always_ff @(posedge refresh_clk or posedge reset) begin
    if (reset) begin
      state_q     <= P1_PLACE;
      p1_map_q    <= {CELLS{1'b0}};
      p2_map_q    <= {CELLS{1'b0}};
      p1_hits_q   <= HIT_ZERO;
      p2_hits_q   <= HIT_ZERO;
      strobe_q    <= 1'b0;
      hit_q       <= 1'b0;
      place_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      p1_map_q    <= p1_map_d;
      p2_map_q    <= p2_map_d;
      p1_hits_q   <= p1_hits_d;
      p2_hits_q   <= p2_hits_d;
      strobe_q    <= strobe_d;
      hit_q       <= hit_d;
      place_err_q <= place_err_d;
    end
  end

  assign game_state  = state_q;
  assign p1_shot_map = p1_map_q;
  assign p2_shot_map = p2_map_q;
  assign p1_hits     = p1_hits_q;
  assign p2_hits     = p2_hits_q;
  assign shot_strobe = strobe_q;
  assign shot_hit    = hit_q;
  assign place_err   = place_err_q;

endmodule

// File: tb/tb_turn_arbiter_fsm.sv
// Directed bench for turn_arbiter_fsm at the default 6x6 / 5-ship / 10-tick
// configuration. Inputs change on the falling edge. Outputs are sampled 1 ns
// after the rising edge that registers them.
module tb_turn_arbiter_fsm;

  logic        refresh_clk;
  logic        reset;
  logic        tick_1hz;
  logic        done_pulse;
  logic        attack_pulse;
  logic [5:0]  cursor_idx;
  logic [35:0] p1_ships;
  logic [35:0] p2_ships;
  logic [2:0]  game_state;
  logic [35:0] p1_shot_map;
  logic [35:0] p2_shot_map;
  logic [2:0]  p1_hits;
  logic [2:0]  p2_hits;
  logic [3:0]  turn_timer;
  logic        shot_strobe;
  logic        shot_hit;
  logic        place_err;

  int checks;
  int errors;

  // P1 ships on cells 0..4, P2 ships on cells 7..11.
  localparam logic [35:0] P1_SHIPS5 = 36'h0_0000_001F;
  localparam logic [35:0] P1_SHIPS4 = 36'h0_0000_000F;
  localparam logic [35:0] P2_SHIPS5 = 36'h0_0000_0F80;

  turn_arbiter_fsm dut (
    .refresh_clk  (refresh_clk),
    .reset        (reset),
    .tick_1hz     (tick_1hz),
    .done_pulse   (done_pulse),
    .attack_pulse (attack_pulse),
    .cursor_idx   (cursor_idx),
    .p1_ships     (p1_ships),
    .p2_ships     (p2_ships),
    .game_state   (game_state),
    .p1_shot_map  (p1_shot_map),
    .p2_shot_map  (p2_shot_map),
    .p1_hits      (p1_hits),
    .p2_hits      (p2_hits),
    .turn_timer   (turn_timer),
    .shot_strobe  (shot_strobe),
    .shot_hit     (shot_hit),
    .place_err    (place_err)
  );

  initial refresh_clk = 1'b0;
  always #5 refresh_clk = ~refresh_clk;

  // Drive one cycle of input pulses, then return 1 ns after the rising edge.
  task automatic step(input logic d, input logic a, input logic [5:0] idx, input logic t);
    @(negedge refresh_clk);
    done_pulse = d; attack_pulse = a; cursor_idx = idx; tick_1hz = t;
    @(posedge refresh_clk);
    #1;
    done_pulse = 1'b0; attack_pulse = 1'b0; tick_1hz = 1'b0;
  endtask

  task automatic apply_reset();
    @(negedge refresh_clk);
    reset = 1'b1; done_pulse = 1'b0; attack_pulse = 1'b0; tick_1hz = 1'b0; cursor_idx = 6'd0;
    @(negedge refresh_clk);
    @(negedge refresh_clk);
    reset = 1'b0;
  endtask

  task automatic place_both();
    p1_ships = P1_SHIPS5; p2_ships = P2_SHIPS5;
    step(1'b1, 1'b0, 6'd0, 1'b0);
    step(1'b1, 1'b0, 6'd0, 1'b0);
  endtask

  task automatic test_reset();
    p1_ships = P1_SHIPS5; p2_ships = P2_SHIPS5;
    apply_reset();
    checks++; if (game_state !== 3'd0) begin errors++; $display("FAIL rst_state: got %0d expected 0", game_state); end
    checks++; if (p1_shot_map !== 36'h0 || p2_shot_map !== 36'h0) begin errors++; $display("FAIL rst_maps: got %h/%h expected 0/0", p1_shot_map, p2_shot_map); end
    checks++; if (p1_hits !== 3'd0 || p2_hits !== 3'd0) begin errors++; $display("FAIL rst_hits: got %0d/%0d expected 0/0", p1_hits, p2_hits); end
    checks++; if (turn_timer !== 4'd10) begin errors++; $display("FAIL rst_timer: got %0d expected 10", turn_timer); end
    checks++; if ({shot_strobe, shot_hit, place_err} !== 3'b000) begin errors++; $display("FAIL rst_strobes: got %b expected 000", {shot_strobe, shot_hit, place_err}); end
  endtask

  task automatic test_placement();
    // An attack during placement is ignored.
    step(1'b0, 1'b1, 6'd7, 1'b0);
    checks++; if (shot_strobe !== 1'b0 || p1_shot_map !== 36'h0 || game_state !== 3'd0) begin errors++; $display("FAIL place_attack_ign: got strobe %b map %h state %0d expected 0 0 0", shot_strobe, p1_shot_map, game_state); end
    // Four ships placed: the request is rejected.
    p1_ships = P1_SHIPS4;
    step(1'b1, 1'b0, 6'd0, 1'b0);
    checks++; if (place_err !== 1'b1) begin errors++; $display("FAIL place_err_pulse: got %b expected 1", place_err); end
    checks++; if (game_state !== 3'd0) begin errors++; $display("FAIL place_err_state: got %0d expected 0", game_state); end
    step(1'b0, 1'b0, 6'd0, 1'b0);
    checks++; if (place_err !== 1'b0) begin errors++; $display("FAIL place_err_clear: got %b expected 0", place_err); end
    p1_ships = P1_SHIPS5;
    step(1'b1, 1'b0, 6'd0, 1'b0);
    checks++; if (game_state !== 3'd1 || place_err !== 1'b0) begin errors++; $display("FAIL place_p1_ok: got state %0d err %b expected 1 0", game_state, place_err); end
    step(1'b1, 1'b0, 6'd0, 1'b0);
    checks++; if (game_state !== 3'd2 || turn_timer !== 4'd10) begin errors++; $display("FAIL place_p2_ok: got state %0d timer %0d expected 2 10", game_state, turn_timer); end
  endtask

  task automatic test_attack();
    step(1'b0, 1'b1, 6'd7, 1'b0);
    checks++; if (shot_strobe !== 1'b1 || shot_hit !== 1'b1) begin errors++; $display("FAIL atk_hit_strobe: got %b%b expected 11", shot_strobe, shot_hit); end
    checks++; if (p1_hits !== 3'd1 || p1_shot_map !== 36'h0_0000_0080) begin errors++; $display("FAIL atk_hit_update: got hits %0d map %h expected 1 000000080", p1_hits, p1_shot_map); end
    checks++; if (game_state !== 3'd3 || turn_timer !== 4'd10) begin errors++; $display("FAIL atk_hit_turn: got state %0d timer %0d expected 3 10", game_state, turn_timer); end
    // P2 misses at cell 20.
    step(1'b0, 1'b1, 6'd20, 1'b0);
    checks++; if (shot_strobe !== 1'b1 || shot_hit !== 1'b0 || p2_hits !== 3'd0) begin errors++; $display("FAIL atk_miss: got strobe %b hit %b hits %0d expected 1 0 0", shot_strobe, shot_hit, p2_hits); end
    checks++; if (p2_shot_map !== 36'h0_0010_0000 || game_state !== 3'd2) begin errors++; $display("FAIL atk_miss_map: got map %h state %0d expected 000100000 2", p2_shot_map, game_state); end
  endtask

  task automatic test_repeat();
    step(1'b0, 1'b1, 6'd7, 1'b0);
    checks++; if (shot_strobe !== 1'b0 || game_state !== 3'd2 || p1_shot_map !== 36'h0_0000_0080) begin errors++; $display("FAIL repeat_ign: got strobe %b state %0d map %h expected 0 2 000000080", shot_strobe, game_state, p1_shot_map); end
    step(1'b0, 1'b1, 6'd36, 1'b0);
    checks++; if (shot_strobe !== 1'b0 || game_state !== 3'd2 || p1_shot_map !== 36'h0_0000_0080) begin errors++; $display("FAIL range_ign: got strobe %b state %0d map %h expected 0 2 000000080", shot_strobe, game_state, p1_shot_map); end
  endtask

  task automatic test_timeout();
    for (int k = 1; k <= 9; k++) begin
      step(1'b0, 1'b0, 6'd0, 1'b1);
      checks++; if (turn_timer !== 4'(10 - k) || game_state !== 3'd2) begin errors++; $display("FAIL tmo_count%0d: got timer %0d state %0d expected %0d 2", k, turn_timer, game_state, 10 - k); end
    end
    step(1'b0, 1'b0, 6'd0, 1'b1);
    checks++; if (game_state !== 3'd3 || turn_timer !== 4'd10 || shot_strobe !== 1'b0) begin errors++; $display("FAIL tmo_forfeit: got state %0d timer %0d strobe %b expected 3 10 0", game_state, turn_timer, shot_strobe); end
    checks++; if (p1_shot_map !== 36'h0_0000_0080 || p2_shot_map !== 36'h0_0010_0000) begin errors++; $display("FAIL tmo_maps: got %h/%h expected 000000080/000100000", p1_shot_map, p2_shot_map); end
    for (int k = 1; k <= 9; k++) begin
      step(1'b0, 1'b0, 6'd0, 1'b1);
    end
    checks++; if (turn_timer !== 4'd1 || game_state !== 3'd3) begin errors++; $display("FAIL tmo_p2_count: got timer %0d state %0d expected 1 3", turn_timer, game_state); end
    // An attack and the expiring tick in the same cycle: the attack wins.
    step(1'b0, 1'b1, 6'd21, 1'b1);
    checks++; if (shot_strobe !== 1'b1 || game_state !== 3'd2 || turn_timer !== 4'd10) begin errors++; $display("FAIL tmo_attack_wins: got strobe %b state %0d timer %0d expected 1 2 10", shot_strobe, game_state, turn_timer); end
    checks++; if (p2_shot_map !== 36'h0_0030_0000) begin errors++; $display("FAIL tmo_attack_map: got %h expected 000300000", p2_shot_map); end
    // An ignored shot together with a tick: the timer still counts down.
    step(1'b0, 1'b1, 6'd7, 1'b1);
    checks++; if (shot_strobe !== 1'b0 || turn_timer !== 4'd9 || game_state !== 3'd2) begin errors++; $display("FAIL ign_tick: got strobe %b timer %0d state %0d expected 0 9 2", shot_strobe, turn_timer, game_state); end
    step(1'b0, 1'b1, 6'd8, 1'b0);
    checks++; if (p1_hits !== 3'd2 || game_state !== 3'd3 || turn_timer !== 4'd10) begin errors++; $display("FAIL hit2: got hits %0d state %0d timer %0d expected 2 3 10", p1_hits, game_state, turn_timer); end
  endtask

  task automatic test_win();
    step(1'b0, 1'b1, 6'd22, 1'b0);
    step(1'b0, 1'b1, 6'd9, 1'b0);
    step(1'b0, 1'b1, 6'd23, 1'b0);
    step(1'b0, 1'b1, 6'd10, 1'b0);
    checks++; if (p1_hits !== 3'd4 || game_state !== 3'd3) begin errors++; $display("FAIL hit4: got hits %0d state %0d expected 4 3", p1_hits, game_state); end
    step(1'b0, 1'b1, 6'd24, 1'b0);
    step(1'b0, 1'b1, 6'd11, 1'b0);
    checks++; if (game_state !== 3'd4 || p1_hits !== 3'd5) begin errors++; $display("FAIL win_state: got state %0d hits %0d expected 4 5", game_state, p1_hits); end
    checks++; if (shot_strobe !== 1'b1 || shot_hit !== 1'b1) begin errors++; $display("FAIL win_strobe: got %b%b expected 11", shot_strobe, shot_hit); end
    // A won game ignores every further request.
    step(1'b1, 1'b1, 6'd12, 1'b1);
    step(1'b0, 1'b1, 6'd13, 1'b1);
    checks++; if (game_state !== 3'd4 || shot_strobe !== 1'b0 || place_err !== 1'b0) begin errors++; $display("FAIL win_absorb: got state %0d strobe %b err %b expected 4 0 0", game_state, shot_strobe, place_err); end
    checks++; if (p1_shot_map !== 36'h0_0000_0F80 || p2_shot_map !== 36'h0_01F0_0000) begin errors++; $display("FAIL win_maps: got %h/%h expected 000000f80/001f00000", p1_shot_map, p2_shot_map); end
    checks++; if (p1_hits !== 3'd5 || p2_hits !== 3'd0 || turn_timer !== 4'd10) begin errors++; $display("FAIL win_frozen: got hits %0d/%0d timer %0d expected 5/0 10", p1_hits, p2_hits, turn_timer); end
  endtask

  task automatic test_reset_mid_game();
    apply_reset();
    place_both();
    step(1'b0, 1'b1, 6'd7, 1'b0);
    step(1'b0, 1'b0, 6'd0, 1'b1);
    checks++; if (game_state !== 3'd3 || turn_timer !== 4'd9) begin errors++; $display("FAIL pre_reset: got state %0d timer %0d expected 3 9", game_state, turn_timer); end
    // Assert reset between clock edges. The outputs must clear at once.
    @(negedge refresh_clk);
    #2 reset = 1'b1;
    #1;
    checks++; if (game_state !== 3'd0 || turn_timer !== 4'd10) begin errors++; $display("FAIL mid_rst_state: got state %0d timer %0d expected 0 10", game_state, turn_timer); end
    checks++; if (p1_shot_map !== 36'h0 || p1_hits !== 3'd0 || shot_strobe !== 1'b0) begin errors++; $display("FAIL mid_rst_regs: got map %h hits %0d strobe %b expected 0 0 0", p1_shot_map, p1_hits, shot_strobe); end
    @(negedge refresh_clk);
    reset = 1'b0;
  endtask

  task automatic test_extra_turn();
    place_both();
    step(1'b0, 1'b0, 6'd0, 1'b1);
    checks++; if (turn_timer !== 4'd9) begin errors++; $display("FAIL xt_tick: got %0d expected 9", turn_timer); end
    step(1'b0, 1'b1, 6'd7, 1'b0);
    checks++; if (shot_hit !== 1'b1 || game_state !== 3'd2 || turn_timer !== 4'd10 || p1_hits !== 3'd1) begin errors++; $display("FAIL xt_hit_keeps: got hit %b state %0d timer %0d hits %0d expected 1 2 10 1", shot_hit, game_state, turn_timer, p1_hits); end
    step(1'b0, 1'b1, 6'd30, 1'b0);
    checks++; if (shot_strobe !== 1'b1 || shot_hit !== 1'b0 || game_state !== 3'd3) begin errors++; $display("FAIL xt_miss_passes: got strobe %b hit %b state %0d expected 1 0 3", shot_strobe, shot_hit, game_state); end
  endtask

  initial begin
    checks = 0; errors = 0;
    reset = 1'b1; tick_1hz = 1'b0; done_pulse = 1'b0; attack_pulse = 1'b0;
    cursor_idx = 6'd0; p1_ships = 36'h0; p2_ships = 36'h0;
    test_reset();
    test_placement();
`ifdef EXTRA_TURN_ON_HIT_EN
    apply_reset();
    test_extra_turn();
`else
    test_attack();
    test_repeat();
    test_timeout();
    test_win();
`endif
    test_reset_mid_game();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
